// File: rtl/divider_pkg.sv
// divider_pkg: shared types and widths for the divider issue stage.
//   OP_W           operand width (dividend / divisor)
//   Q_W            quotient width returned by the divider
//   feeder_state_t issue FSM state encoding
//   div_req_t      one queued operand pair
package divider_pkg;

  localparam int OP_W = 8;
  localparam int Q_W  = 9;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } feeder_state_t;

  typedef struct packed {
    logic [OP_W-1:0] dividend;
    logic [OP_W-1:0] divisor;
  } div_req_t;

endpackage

// File: rtl/divider_feeder_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
//   clk, reset        clock, synchronous active-high reset
//   push, wr_data     write request / data (ignored while full)
//   pop, rd_data      read request (ignored while empty) / head entry
//   full, empty       occupancy flags derived from count
//   count             number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/divider_feeder.sv
// divider_feeder: queues operand pairs and issues them one at a time to the
// divider's start/busy/finish handshake, returning quotients in order.
//   clk_i, reset_i                          clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_dividend_i/in_divisor_i   operand stream in
//   div_start_o/div_dividend_o/div_divisor_o           divider request
//   div_busy_i/div_finish_i/div_quotient_i             divider status/result
//   out_valid_o/out_ready_i/out_quotient_o/out_dividend_o/out_divisor_o
//                                                      result stream out
//   pending_o                                          FIFO occupancy
//
// state | meaning
// IDLE  | waiting for a queued pair and an idle divider; pops the head
// ISSUE | one-cycle start pulse, operands already on div_*
// WAIT  | operands held; first finish sample captures the quotient
// HOLD  | result offered on out_*, leaves on out_ready_i
import divider_pkg::*;

module divider_feeder #(
  parameter int DEPTH = 4,
  parameter int OP_W  = divider_pkg::OP_W,
  parameter int Q_W   = divider_pkg::Q_W
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [OP_W-1:0]          in_dividend_i,
  input  logic [OP_W-1:0]          in_divisor_i,
  output logic                     div_start_o,
  output logic [OP_W-1:0]          div_dividend_o,
  output logic [OP_W-1:0]          div_divisor_o,
  input  logic                     div_busy_i,
  input  logic                     div_finish_i,
  input  logic [Q_W-1:0]           div_quotient_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [Q_W-1:0]           out_quotient_o,
  output logic [OP_W-1:0]          out_dividend_o,
  output logic [OP_W-1:0]          out_divisor_o,
  output logic [$clog2(DEPTH):0]   pending_o
);

  feeder_state_t   state;
  feeder_state_t   state_nxt;
  div_req_t        fifo_wr;
  div_req_t        fifo_rd;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic            push;
  logic            capture;
  logic [OP_W-1:0] dividend_q;
  logic [OP_W-1:0] divisor_q;
  logic [Q_W-1:0]  quotient_q;

  // Ready is taken from the registered count only; a pop in the same cycle
  // does not reopen a full FIFO.
  assign in_ready_o       = !fifo_full;
  assign push             = in_valid_i && in_ready_o;
  assign fifo_wr.dividend = in_dividend_i;
  assign fifo_wr.divisor  = in_divisor_i;

  sync_fifo #(
    .WIDTH ($bits(div_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .reset   (reset_i),
    .push    (push),
    .wr_data (fifo_wr),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (pending_o)
  );

  always_comb begin
    state_nxt   = state;
    fifo_pop    = 1'b0;
    div_start_o = 1'b0;
    out_valid_o = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !div_busy_i) begin
          fifo_pop  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        div_start_o = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (div_finish_i) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid_o = 1'b1;
        // Returning through IDLE keeps a lingering finish level away from
        // the next job's WAIT.
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      quotient_q <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) begin
        dividend_q <= fifo_rd.dividend;
        divisor_q  <= fifo_rd.divisor;
      end
      if (capture) quotient_q <= div_quotient_i;
    end
  end

  // One operand register pair feeds both the divider and the echoed result,
  // so it stays stable from issue through the output handshake.
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign out_dividend_o = dividend_q;
  assign out_divisor_o  = divisor_q;
  assign out_quotient_o = quotient_q;

endmodule

// File: tb/tb_divider_feeder.sv
module tb_divider_feeder;

  logic       clk_i;
  logic       reset_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_dividend_i;
  logic [7:0] in_divisor_i;
  logic       div_start_o;
  logic [7:0] div_dividend_o;
  logic [7:0] div_divisor_o;
  logic       div_busy_i;
  logic       div_finish_i;
  logic [8:0] div_quotient_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [8:0] out_quotient_o;
  logic [7:0] out_dividend_o;
  logic [7:0] out_divisor_o;
  logic [2:0] pending_o;

  int n_vec  = 0;
  int n_miss = 0;

  divider_feeder #(.DEPTH(4), .OP_W(8), .Q_W(9)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_dividend_i  (in_dividend_i),
    .in_divisor_i   (in_divisor_i),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_busy_i     (div_busy_i),
    .div_finish_i   (div_finish_i),
    .div_quotient_i (div_quotient_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_quotient_o (out_quotient_o),
    .out_dividend_o (out_dividend_o),
    .out_divisor_o  (out_divisor_o),
    .pending_o      (pending_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Divider stand-in: 9-cycle latency, one-cycle finish pulse, all-ones for
  // divide by zero. Manual overrides are used when model_en is low.
  logic       model_en;
  logic       m_busy, m_finish;
  logic [8:0] m_q;
  int         m_lat;
  logic       man_busy, man_finish;
  logic [8:0] man_q;

  assign div_busy_i     = model_en ? m_busy   : man_busy;
  assign div_finish_i   = model_en ? m_finish : man_finish;
  assign div_quotient_i = model_en ? m_q      : man_q;

  initial begin
    m_busy = 0; m_finish = 0; m_q = '0; m_lat = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i || !model_en) begin
        m_busy = 0; m_finish = 0; m_lat = 0;
      end else begin
        if (m_finish) m_finish = 0;
        if (m_lat > 0) begin
          m_lat--;
          if (m_lat == 0) begin
            m_finish = 1;
            m_busy   = 0;
          end
        end else if (div_start_o) begin
          m_busy = 1;
          m_lat  = 9;
          m_q    = (div_divisor_o == 0) ? 9'h1FF : 9'(div_dividend_o / div_divisor_o);
        end
      end
    end
  end

  // Output handshakes, recorded as {quotient, dividend, divisor}.
  logic [24:0] res_q[$];
  initial begin
    forever begin
      @(negedge clk_i);
      if (out_valid_o && out_ready_i)
        res_q.push_back({out_quotient_o, out_dividend_o, out_divisor_o});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_results(input string tag, input int n);
    int b = 0;
    while (res_q.size() < n && b < 400) begin
      tick(1);
      b++;
    end
    chk({tag, "_count"}, res_q.size(), n);
  endtask

  task automatic chk_res(input string tag, input int idx, input int q, input int dd, input int dv);
    logic [24:0] r;
    r = (idx < res_q.size()) ? res_q[idx] : 25'h1FFFFFF;
    chk({tag, "_q"},  r[24:16], q);
    chk({tag, "_dd"}, r[15:8],  dd);
    chk({tag, "_dv"}, r[7:0],   dv);
  endtask

  int bd[4] = '{200, 255, 9, 0};
  int bv[4] = '{10, 1, 3, 5};
  int bq[4] = '{20, 255, 3, 0};
  int fd[6] = '{50, 81, 7, 1, 240, 99};
  int fv[6] = '{5, 9, 2, 1, 16, 0};
  int fq[6] = '{10, 9, 3, 1, 15, 511};

  initial begin
    int b;
    int bad;
    int starts;

    reset_i = 1; in_valid_i = 0; in_dividend_i = 0; in_divisor_i = 0;
    out_ready_i = 1; model_en = 1; man_busy = 0; man_finish = 0; man_q = '0;
    tick(2);
    reset_i = 0;
    tick(1);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_pending", pending_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_start", div_start_o, 0);
    chk("rst_out_q", out_quotient_o, 0);
    chk("rst_div_dd", div_dividend_o, 0);

    // Single job: start two cycles after the push, 100/7 = 14.
    res_q.delete();
    in_valid_i = 1; in_dividend_i = 100; in_divisor_i = 7;
    tick(1);
    in_valid_i = 0;
    chk("t1_pend1", pending_o, 1);
    chk("t1_start_early", div_start_o, 0);
    tick(1);
    chk("t1_start", div_start_o, 1);
    chk("t1_pend0", pending_o, 0);
    chk("t1_div_dd", div_dividend_o, 100);
    chk("t1_div_dv", div_divisor_o, 7);
    tick(1);
    chk("t1_start_once", div_start_o, 0);
    wait_results("t1", 1);
    chk_res("t1", 0, 14, 100, 7);
    chk("t1_pend_end", pending_o, 0);
    tick(3);

    // Burst of four back-to-back pairs.
    res_q.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1; in_dividend_i = 8'(bd[i]); in_divisor_i = 8'(bv[i]);
      chk("burst_ready", in_ready_o, 1);
      tick(1);
    end
    in_valid_i = 0;
    wait_results("burst", 4);
    for (int i = 0; i < 4; i++) chk_res("burst", i, bq[i], bd[i], bv[i]);
    tick(3);

    // Full FIFO with output stalled: first pair goes in flight, next four fill.
    res_q.delete();
    out_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1; in_dividend_i = 8'(fd[i]); in_divisor_i = 8'(fv[i]);
      chk("full_ready", in_ready_o, 1);
      tick(1);
    end
    in_dividend_i = 8'(fd[5]); in_divisor_i = 8'(fv[5]);
    chk("full_pend4", pending_o, 4);
    chk("full_not_ready", in_ready_o, 0);
    tick(20);
    chk("full_pend_hold", pending_o, 4);
    chk("full_still_blocked", in_ready_o, 0);
    chk("full_hold_valid", out_valid_o, 1);
    chk("full_hold_q", out_quotient_o, 10);
    out_ready_i = 1;
    b = 0;
    while (!in_ready_o && b < 100) begin
      tick(1);
      b++;
    end
    chk("full_reopen", in_ready_o, 1);
    tick(1);
    in_valid_i = 0;
    wait_results("full", 6);
    for (int i = 0; i < 6; i++) chk_res("full", i, fq[i], fd[i], fv[i]);
    tick(40);
    chk("full_no_dup", res_q.size(), 6);

    // Backpressure: result held 20 cycles, next issue one cycle after handshake.
    res_q.delete();
    out_ready_i = 0;
    in_valid_i = 1; in_dividend_i = 60; in_divisor_i = 4;
    tick(1);
    in_dividend_i = 33; in_divisor_i = 11;
    tick(1);
    in_valid_i = 0;
    b = 0;
    while (!out_valid_o && b < 100) begin
      tick(1);
      b++;
    end
    chk("bp_hold", out_valid_o, 1);
    bad = 0; starts = 0;
    repeat (20) begin
      tick(1);
      if (!out_valid_o || out_quotient_o != 15 || out_dividend_o != 60 || out_divisor_o != 4) bad++;
      if (div_start_o) starts++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_no_start", starts, 0);
    chk("bp_pend", pending_o, 1);
    out_ready_i = 1;
    tick(1);
    chk("bp_start_gap", div_start_o, 0);
    chk("bp_valid_drop", out_valid_o, 0);
    tick(1);
    chk("bp_start", div_start_o, 1);
    chk("bp_next_dd", div_dividend_o, 33);
    wait_results("bp", 2);
    chk_res("bp0", 0, 15, 60, 4);
    chk_res("bp1", 1, 3, 33, 11);
    tick(3);

    // Stray finish in IDLE, busy blocking issue, lingering finish after HOLD.
    res_q.delete();
    model_en = 0;
    man_finish = 1; man_q = 9'd77;
    tick(3);
    chk("stray_valid", out_valid_o, 0);
    chk("stray_start", div_start_o, 0);
    chk("stray_pend", pending_o, 0);
    man_finish = 0; man_busy = 1;
    in_valid_i = 1; in_dividend_i = 12; in_divisor_i = 4;
    tick(1);
    in_valid_i = 0;
    tick(5);
    chk("busy_no_start", div_start_o, 0);
    chk("busy_pend", pending_o, 1);
    man_busy = 0;
    tick(1);
    chk("busy_release_start", div_start_o, 1);
    tick(1);
    man_q = 9'd3; man_finish = 1;
    tick(1);
    chk("man_hold_valid", out_valid_o, 1);
    chk("man_hold_q", out_quotient_o, 3);
    tick(1);
    chk("linger_valid0", out_valid_o, 0);
    tick(2);
    chk("linger_valid1", out_valid_o, 0);
    chk("linger_count", res_q.size(), 1);
    man_finish = 0;
    model_en = 1;
    tick(3);

    // Reset while in WAIT with two entries queued.
    res_q.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1; in_dividend_i = 8'(11 * (i + 1)); in_divisor_i = 8'(i + 1);
      tick(1);
    end
    in_valid_i = 0;
    chk("mid_pend", pending_o, 2);
    chk("mid_div_dd", div_dividend_o, 11);
    reset_i = 1;
    tick(1);
    chk("mrst_in_ready", in_ready_o, 1);
    chk("mrst_pending", pending_o, 0);
    chk("mrst_valid", out_valid_o, 0);
    chk("mrst_start", div_start_o, 0);
    chk("mrst_div_dd", div_dividend_o, 0);
    chk("mrst_div_dv", div_divisor_o, 0);
    chk("mrst_out_q", out_quotient_o, 0);
    reset_i = 0;
    tick(20);
    chk("mrst_no_result", res_q.size(), 0);
    chk("mrst_idle_start", div_start_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
